// File: rtl/fp21_pkg.sv
// Shared FP21 definitions: field widths, packed-word layout and the pack helper.
package fp21_pkg;

  localparam int EXP_W    = 7;
  localparam int FRAC_W   = 13;
  localparam int MAG_W    = 16;
  localparam int LZ_W     = 4;
  localparam int WORD_W   = 1 + EXP_W + FRAC_W;
  localparam int BIAS     = 63;
  localparam logic [EXP_W-1:0] EXP_INF = 7'h7F;

  localparam int FRAC_LSB = 0;
  localparam int EXP_LSB  = FRAC_W;
  localparam int SIGN_POS = EXP_W + FRAC_W;

  typedef enum logic [2:0] {
    RES_NORM = 3'd0,
    RES_INF  = 3'd1,
    RES_ZERO = 3'd2,
    RES_OF   = 3'd3,
    RES_UF   = 3'd4
  } res_kind_e;

  function automatic logic [WORD_W-1:0] fp21_pack(input logic sign,
                                                  input logic [EXP_W-1:0] exp,
                                                  input logic [FRAC_W-1:0] frac);
    logic [WORD_W-1:0] w_word;
    w_word                      = '0;
    w_word[SIGN_POS]            = sign;
    w_word[EXP_LSB +: EXP_W]    = exp;
    w_word[FRAC_LSB +: FRAC_W]  = frac;
    return w_word;
  endfunction

endpackage

// File: rtl/fp21_round_pack.sv
// Final stage: round-to-nearest-even, exception precedence and packing into FP21.
module fp21_round_pack
  import fp21_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  input  logic                 i_sign,
  input  logic                 i_inf,
  input  logic                 i_zero,
  input  logic [14:0]          i_shifted,
  input  logic signed [8:0]    i_exp,
  output logic                 o_valid,
  output logic [WORD_W-1:0]    o_data,
  output logic                 o_of,
  output logic                 o_uf
);

  logic [FRAC_W-1:0]  w_frac;
  logic               w_guard;
  logic               w_sticky;
  logic               w_round_up;
  logic [FRAC_W:0]    w_frac_sum;
  logic signed [8:0]  w_exp_fin;
  res_kind_e          w_kind;
  logic [WORD_W-1:0]  w_next_data;

  assign w_frac     = i_shifted[14:2];
  assign w_guard    = i_shifted[1];
  assign w_sticky   = i_shifted[0];
  assign w_round_up = w_guard & (w_sticky | w_frac[0]);
  // A carry out of the fraction leaves the low bits at zero and bumps the exponent.
  assign w_frac_sum = {1'b0, w_frac} + {{FRAC_W{1'b0}}, w_round_up};
  assign w_exp_fin  = i_exp + $signed({8'd0, w_frac_sum[FRAC_W]});

  always_comb begin
    w_kind = RES_NORM;
    if (i_inf) begin
      w_kind = RES_INF;
    end else if (i_zero) begin
      w_kind = RES_ZERO;
    end else if (w_exp_fin >= 9'sd127) begin
      w_kind = RES_OF;
    end else if (w_exp_fin <= 9'sd0) begin
      w_kind = RES_UF;
    end else begin
      w_kind = RES_NORM;
    end
  end

  always_comb begin
    w_next_data = '0;
    case (w_kind)
      RES_INF, RES_OF:  w_next_data = fp21_pack(i_sign, EXP_INF, {FRAC_W{1'b0}});
      RES_ZERO, RES_UF: w_next_data = fp21_pack(i_sign, {EXP_W{1'b0}}, {FRAC_W{1'b0}});
      RES_NORM:         w_next_data = fp21_pack(i_sign, w_exp_fin[EXP_W-1:0], w_frac_sum[FRAC_W-1:0]);
      default:          w_next_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_of    <= 1'b0;
      o_uf    <= 1'b0;
    end else begin
      o_valid <= i_valid;
      o_of    <= i_valid & (w_kind == RES_OF);
      o_uf    <= i_valid & (w_kind == RES_UF);
      if (i_valid) begin
        o_data <= w_next_data;
      end else begin
        o_data <= o_data;
      end
    end
  end

endmodule

// File: rtl/sixteen_bit_LZC.sv
// Registered 16-bit leading-zero counter; an all-zero input reports 15.
module sixteen_bit_LZC (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_data,
  output logic [3:0]  o_count
);

  logic [3:0] w_count;

  // Ascending scan: the highest set bit is the last writer.
  always_comb begin
    w_count = 4'd15;
    for (int i = 0; i < 16; i++) begin
      w_count = i_data[i] ? 4'(15 - i) : w_count;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_count <= 4'd0;
    end else begin
      o_count <= w_count;
    end
  end

endmodule

// File: rtl/fp21_normalize_round.sv
// FP21 post-add normalizer: LZC-driven left shift, exponent adjust, RNE rounding, packing.
module fp21_normalize_round
  import fp21_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                in_sign,
  input  logic [EXP_W-1:0]    in_exp,
  input  logic [MAG_W-1:0]    in_mag,
  input  logic                in_inf,
  output logic                out_valid,
  output logic [WORD_W-1:0]   out_data,
  output logic                out_of,
  output logic                out_uf
);

  logic               r_s1_valid;
  logic               r_s1_sign;
  logic [EXP_W-1:0]   r_s1_exp;
  logic [MAG_W-1:0]   r_s1_mag;
  logic               r_s1_inf;
  logic               r_s1_zero;
  logic [LZ_W-1:0]    w_lz;

  logic               r_s2_valid;
  logic               r_s2_sign;
  logic               r_s2_inf;
  logic               r_s2_zero;
  logic [14:0]        r_s2_shifted;
  logic signed [8:0]  r_s2_exp;

  logic [14:0]        w_shifted;
  logic signed [8:0]  w_exp_adj;

  // The LZC registers on the same edge as S1, so w_lz lines up with r_s1_mag.
  sixteen_bit_LZC u_lzc (
    .clk     (clk),
    .rst     (rst),
    .i_data  (in_mag),
    .o_count (w_lz)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_exp   <= '0;
      r_s1_mag   <= '0;
      r_s1_inf   <= 1'b0;
      r_s1_zero  <= 1'b0;
    end else begin
      r_s1_valid <= in_valid;
      r_s1_sign  <= in_sign;
      r_s1_exp   <= in_exp;
      r_s1_mag   <= in_mag;
      r_s1_inf   <= in_inf;
      r_s1_zero  <= (in_mag == 16'd0);
    end
  end

  // Bit 15 of the shifted magnitude is the hidden one and is not carried forward.
  assign w_shifted = 15'(r_s1_mag << w_lz);
  assign w_exp_adj = $signed({2'b00, r_s1_exp}) + 9'sd1 - $signed({5'd0, w_lz});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid   <= 1'b0;
      r_s2_sign    <= 1'b0;
      r_s2_inf     <= 1'b0;
      r_s2_zero    <= 1'b0;
      r_s2_shifted <= '0;
      r_s2_exp     <= '0;
    end else begin
      r_s2_valid   <= r_s1_valid;
      r_s2_sign    <= r_s1_sign;
      r_s2_inf     <= r_s1_inf;
      r_s2_zero    <= r_s1_zero;
      r_s2_shifted <= w_shifted;
      r_s2_exp     <= w_exp_adj;
    end
  end

  fp21_round_pack u_round_pack (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (r_s2_valid),
    .i_sign    (r_s2_sign),
    .i_inf     (r_s2_inf),
    .i_zero    (r_s2_zero),
    .i_shifted (r_s2_shifted),
    .i_exp     (r_s2_exp),
    .o_valid   (out_valid),
    .o_data    (out_data),
    .o_of      (out_of),
    .o_uf      (out_uf)
  );

endmodule

// File: doc/fp21_normalize_round.md
Name: fp21_normalize_round

Overview:
- Post-add normalization stage for the FP21 datapath (1 sign / 7 exponent, bias 63 / 13 fraction).
- Consumes the raw signed-magnitude result of the FP21 adder: sign, pre-normalization exponent and a 16-bit magnitude.
- Instantiates sixteen_bit_LZC to find the leading one, left-shifts, adjusts the exponent, rounds to nearest-even and packs a 21-bit word.
- Fully pipelined, valid-only (no backpressure), 1 result/cycle, sits directly downstream of the LZC.

Parameters:
- EXP_W, 7, exponent field width.
- FRAC_W, 13, fraction field width.
- BIAS, 63, exponent bias; exponent 0 = zero, exponent 127 = infinity.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input beat valid
- in_sign  in  1  result sign
- in_exp  in  7  exponent referenced to mag bit 14 (value = mag * 2^(in_exp-BIAS-14))
- in_mag  in  16  unnormalized magnitude; bit 15 = adder carry, bits 1:0 = guard/sticky
- in_inf  in  1  force infinity (upstream operand was inf)
- out_valid  out  1  result valid
- out_data  out  21  packed {sign, exp[6:0], frac[12:0]}
- out_of  out  1  overflow to infinity occurred
- out_uf  out  1  underflow flushed to zero

Behaviour:
- Reset: out_valid=0, out_data=0, out_of=0, out_uf=0, all internal valid bits 0; asserting rst mid-stream drops every in-flight beat on the same edge.
- Latency: exactly 3 cycles from in_valid high to out_valid high; a new beat is accepted every cycle.
- S1 (cycle 1): register sign, exp, mag, inf and zero flag (mag==0), alongside valid. The LZC registers its 4-bit count on the same edge, so the count is aligned with S1.
- S2 (cycle 2):
  - shifted = in_mag << lz (16 bits).
  - Signed 9-bit exponent: e = in_exp + 1 - lz.
- S3 (cycle 3):
  - frac = shifted[14:2], guard = shifted[1], sticky = shifted[0].
  - Round up if guard & (sticky | frac[0]).
  - Fraction carry-out sets frac=0 and e=e+1.
  - Pack result, register outputs with valid.
- Precedence, highest first:
  1. in_inf → {sign, 7'h7F, 0}, out_of=0.
  2. zero flag → {sign, 0, 0}, out_uf=0; the LZC count is ignored.
  3. Final e ≥ 127 → {sign, 7'h7F, 0}, out_of=1.
  4. Final e ≤ 0 → {sign, 0, 0}, out_uf=1 (flush-to-zero, no denormals).
  5. Otherwise the normal result.
- Flags are per-beat and valid only with out_valid; when out_valid=0, out_of and out_uf are 0.
- out_data holds its last value when out_valid=0.
- Bubbles (in_valid=0) propagate as bubbles; data regs may update freely, valid regs gate them.

Decomposition:
- Shared package fp21_pkg:
  - FP21 field widths, BIAS, EXP_INF=7'h7F.
  - Packed-word field offsets.
  - A pack function {sign, exp, frac}.
- Sub-module fp21_round_pack (S3 rounding, exception precedence, packing). sixteen_bit_LZC is reused unmodified.

Test Plan:
- in_mag=16'h4000, in_exp=63, sign 0 → 3 cycles later out_data=21'h07E000, flags 0.
- in_mag=16'h8000, in_exp=63 → 21'h080000; in_mag=16'h0001, in_exp=63 → 21'h062000 (lz=15).
- Rounding:
  - in_mag=16'h4001, exp 63 → 21'h07E000 (tie, stays even).
  - 16'h4003 → 21'h07E002.
  - 16'h7FFF → 21'h080000 (round carry bumps exponent).
- Exceptions:
  - in_exp=126, mag 16'h8000, sign 1 → 21'h1FE000, out_of=1.
  - in_exp=5, mag 16'h0001 → 21'h000000, out_uf=1.
  - mag=0, sign 1 → 21'h100000, flags 0.
  - in_inf=1 → inf, out_of=0.
- Throughput: 20 back-to-back random beats with bubbles, compared against a reference model → every result appears exactly 3 cycles after its input, in order, none lost.
- Assert rst while 3 beats are in flight → out_valid=0 on the following cycles, no stale beat emerges; a beat issued the cycle after rst deasserts emerges 3 cycles later.
